int_operand_stage: RTL and testbench
====================================

Name: int_operand_stage

Overview:
- Issue-to-execute pipeline stage sitting directly upstream of the integer ALU.
- Accepts decoded micro-ops from decode/register-read and resolves operands:
  - register-file value, or
  - bypass from execute/memory stage, or
  - PC / immediate / zero.
- Presents registered `alucode`/`op1`/`op2`/`rd` to the ALU.
- valid/ready handshake on both sides; 1-entry skid buffer gives a registered `inReady` and full throughput.

Parameters:
- `DATA_WIDTH`, 32, operand/result width (BasicData).
- `REG_ADDR_WIDTH`, 5, architectural register index width.
- `ALUCODE_WIDTH`, 4, ALU operation code width.

Ports:
- `clk`  in  1  clock; all state on rising edge.
- `rst`  in  1  asynchronous active-high reset.
- `flush`  in  1  discard all held micro-ops (branch mispredict/trap).
- `inValid`  in  1  upstream micro-op valid.
- `inReady`  out  1  stage can accept; registered.
- `inAluCode`  in  ALUCODE_WIDTH  ALU operation.
- `inRs1`, `inRs2`  in  REG_ADDR_WIDTH  source register indices.
- `inRd`  in  REG_ADDR_WIDTH  destination index; 0 = no write.
- `inRf1`, `inRf2`  in  DATA_WIDTH  register-file read data.
- `inPc`  in  DATA_WIDTH  instruction PC.
- `inImm`  in  DATA_WIDTH  sign-extended immediate.
- `inOp1Sel`  in  2  0=rs1, 1=pc, 2=zero, 3=zero.
- `inOp2Sel`  in  2  0=rs2, 1=imm, 2=pc, 3=zero.
- `exFwdValid`, `exFwdRd`, `exFwdData`  in  1/REG_ADDR_WIDTH/DATA_WIDTH  execute-stage result bypass (combinational ALU output of `outValid` op).
- `memFwdValid`, `memFwdRd`, `memFwdData`  in  1/REG_ADDR_WIDTH/DATA_WIDTH  memory-stage result bypass.
- `outValid`  out  1  micro-op presented to ALU.
- `outReady`  in  1  execute stage consumes.
- `outAluCode`  out  ALUCODE_WIDTH  to ALU `alucode`.
- `outOp1`, `outOp2`  out  DATA_WIDTH  to ALU `op1`/`op2`.
- `outRd`  out  REG_ADDR_WIDTH  destination, passed down.

Behaviour:
- Reset (async, `rst`=1): `outValid`=0, skid valid=0, `inReady`=1, `outAluCode`/`outOp1`/`outOp2`/`outRd`=0.
- Transfer rules:
  - accept when `inValid`&&`inReady`;
  - consume when `outValid`&&`outReady`.
- Operand resolution happens at acceptance; resolved values are frozen in the skid/output registers.
  - rs source priority: ex bypass (valid && rd==rs && rs!=0) > mem bypass (same rule) > `inRf`.
  - rs==0 always yields 0, regardless of bypass or RF.
  - Then apply sel muxes.
- State (outputs, skid): EMPTY(0,0), ONE(1,0), FULL(1,1).
  - EMPTY: accept → ONE; accepted op in output reg next cycle. Latency 1 cycle, input to `outValid`.
  - ONE:
    - accept && consume → ONE with new op;
    - consume only → EMPTY;
    - accept only → FULL, new op into skid.
  - FULL: `inReady`=0.
    - consume → skid moves to output, → ONE;
    - else hold.
- `inReady` = !skidValid (registered). Never accepts in FULL.
- Outputs stable while `outValid` && !`outReady`.
- `flush` (synchronous, highest priority): next state EMPTY; same-cycle accept is dropped; `inReady`=1 next cycle.
- Simultaneous bypass hits from ex and mem on the same rs: ex wins.
- Data widths are uniform; no extension or truncation inside the block.

Optional Feature:
- Macro `INT_OPERAND_WB_BYPASS_EN`.
- Defined:
  - adds ports `wbFwdValid` (1), `wbFwdRd` (REG_ADDR_WIDTH), `wbFwdData` (DATA_WIDTH);
  - third bypass level, priority ex > mem > wb > RF; same rs==0 rule.
- Undefined: ports absent; RF assumed write-before-read; priority ex > mem > RF.

Test Plan:
1. Reset mid-stream: hold FULL state, assert `rst` → `outValid`=0, `inReady`=1 immediately; all outputs 0.
2. Back-to-back ADD, `outReady`=1:
   - op rs1=1 (RF 5), rs2=2 (RF 7), sel 0/0, alucode=ALU_ADD;
   - → next cycle `outOp1`=5, `outOp2`=7, one op per cycle sustained.
3. Bypass priority:
   - rs1=3; ex fwd rd=3 data=0x11; mem fwd rd=3 data=0x22; RF=0x33 → `outOp1`=0x11;
   - drop ex valid → 0x22;
   - rs1=0 with fwd rd=0 data=0xFF → 0.
4. Backpressure:
   - `outReady`=0, accept A then B → FULL, `inReady`=0 next cycle, `outOp1` holds A;
   - `outReady`=1 → B presented, `inReady`=1.
5. Flush in FULL with `inValid`=1 → EMPTY next cycle, `outValid`=0, new op not captured.
6. JAL-style op: `inOp2Sel`=2, `inPc`=0x100, alucode=ALU_JUMP → `outOp2`=0x100 (ALU yields 0x104).
   - With `INT_OPERAND_WB_BYPASS_EN`: wb fwd rd=4 data=9, RF=1, rs2=4 → `outOp2`=9.

Source files
------------

// File: rtl/int_operand_stage_if.sv
// Issue-to-execute bundle: upstream micro-op, result bypasses, ALU side.
// Optional wb bypass signals exist only with INT_OPERAND_WB_BYPASS_EN.
interface int_operand_stage_if #(
  parameter int DATA_WIDTH     = 32,
  parameter int REG_ADDR_WIDTH = 5,
  parameter int ALUCODE_WIDTH  = 4
);
  logic                      inValid;
  logic                      inReady;
  logic [ALUCODE_WIDTH-1:0]  inAluCode;
  logic [REG_ADDR_WIDTH-1:0] inRs1;
  logic [REG_ADDR_WIDTH-1:0] inRs2;
  logic [REG_ADDR_WIDTH-1:0] inRd;
  logic [DATA_WIDTH-1:0]     inRf1;
  logic [DATA_WIDTH-1:0]     inRf2;
  logic [DATA_WIDTH-1:0]     inPc;
  logic [DATA_WIDTH-1:0]     inImm;
  logic [1:0]                inOp1Sel;
  logic [1:0]                inOp2Sel;
  logic                      exFwdValid;
  logic [REG_ADDR_WIDTH-1:0] exFwdRd;
  logic [DATA_WIDTH-1:0]     exFwdData;
  logic                      memFwdValid;
  logic [REG_ADDR_WIDTH-1:0] memFwdRd;
  logic [DATA_WIDTH-1:0]     memFwdData;
`ifdef INT_OPERAND_WB_BYPASS_EN
  logic                      wbFwdValid;
  logic [REG_ADDR_WIDTH-1:0] wbFwdRd;
  logic [DATA_WIDTH-1:0]     wbFwdData;
`endif
  logic                      outValid;
  logic                      outReady;
  logic [ALUCODE_WIDTH-1:0]  outAluCode;
  logic [DATA_WIDTH-1:0]     outOp1;
  logic [DATA_WIDTH-1:0]     outOp2;
  logic [REG_ADDR_WIDTH-1:0] outRd;

  modport master (
    output inValid, inAluCode, inRs1, inRs2, inRd,
    output inRf1, inRf2, inPc, inImm, inOp1Sel, inOp2Sel,
    output exFwdValid, exFwdRd, exFwdData,
    output memFwdValid, memFwdRd, memFwdData,
`ifdef INT_OPERAND_WB_BYPASS_EN
    output wbFwdValid, wbFwdRd, wbFwdData,
`endif
    output outReady,
    input  inReady, outValid, outAluCode,
    input  outOp1, outOp2, outRd
  );

  modport slave (
    input  inValid, inAluCode, inRs1, inRs2, inRd,
    input  inRf1, inRf2, inPc, inImm, inOp1Sel, inOp2Sel,
    input  exFwdValid, exFwdRd, exFwdData,
    input  memFwdValid, memFwdRd, memFwdData,
`ifdef INT_OPERAND_WB_BYPASS_EN
    input  wbFwdValid, wbFwdRd, wbFwdData,
`endif
    input  outReady,
    output inReady, outValid, outAluCode,
    output outOp1, outOp2, outRd
  );
endinterface

// File: rtl/int_operand_stage.sv
// Operand resolve stage ahead of the integer ALU, 1-entry skid buffer.
// INT_OPERAND_WB_BYPASS_EN adds a writeback bypass level below mem.
module int_operand_stage #(
  parameter int DATA_WIDTH     = 32,
  parameter int REG_ADDR_WIDTH = 5,
  parameter int ALUCODE_WIDTH  = 4
) (
  input logic               clk,
  input logic               rst,
  input logic               flush,
  int_operand_stage_if.slave bus
);
  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    FULL  = 2'd2
  } state_t;

  state_t r_state, w_next;

  logic [ALUCODE_WIDTH-1:0]  r_outAlu, r_skAlu;
  logic [DATA_WIDTH-1:0]     r_outOp1, r_skOp1;
  logic [DATA_WIDTH-1:0]     r_outOp2, r_skOp2;
  logic [REG_ADDR_WIDTH-1:0] r_outRd, r_skRd;

  logic [DATA_WIDTH-1:0] w_rs1, w_rs2, w_op1, w_op2;
  logic w_accept, w_consume;
  logic w_loadOut, w_fromSkid, w_loadSkid;

  assign bus.inReady    = (r_state != FULL);
  assign bus.outValid   = (r_state != EMPTY);
  assign bus.outAluCode = r_outAlu;
  assign bus.outOp1     = r_outOp1;
  assign bus.outOp2     = r_outOp2;
  assign bus.outRd      = r_outRd;

  assign w_accept  = bus.inValid && (r_state != FULL);
  assign w_consume = (r_state != EMPTY) && bus.outReady;

  // Later assignments win: ex > mem > (wb) > RF, and x0 beats all.
  always_comb begin
    w_rs1 = bus.inRf1;
    w_rs2 = bus.inRf2;
`ifdef INT_OPERAND_WB_BYPASS_EN
    if (bus.wbFwdValid && bus.wbFwdRd == bus.inRs1)
      w_rs1 = bus.wbFwdData;
    if (bus.wbFwdValid && bus.wbFwdRd == bus.inRs2)
      w_rs2 = bus.wbFwdData;
`endif
    if (bus.memFwdValid && bus.memFwdRd == bus.inRs1)
      w_rs1 = bus.memFwdData;
    if (bus.memFwdValid && bus.memFwdRd == bus.inRs2)
      w_rs2 = bus.memFwdData;
    if (bus.exFwdValid && bus.exFwdRd == bus.inRs1)
      w_rs1 = bus.exFwdData;
    if (bus.exFwdValid && bus.exFwdRd == bus.inRs2)
      w_rs2 = bus.exFwdData;
    if (bus.inRs1 == '0)
      w_rs1 = '0;
    if (bus.inRs2 == '0)
      w_rs2 = '0;
  end

  always_comb begin
    unique case (bus.inOp1Sel)
      2'd0:    w_op1 = w_rs1;
      2'd1:    w_op1 = bus.inPc;
      default: w_op1 = '0;
    endcase
    unique case (bus.inOp2Sel)
      2'd0:    w_op2 = w_rs2;
      2'd1:    w_op2 = bus.inImm;
      2'd2:    w_op2 = bus.inPc;
      default: w_op2 = '0;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= EMPTY;
    else     r_state <= w_next;
  end

  always_comb begin
    w_next     = r_state;
    w_loadOut  = 1'b0;
    w_fromSkid = 1'b0;
    w_loadSkid = 1'b0;
    if (flush) begin
      w_next = EMPTY;
    end else begin
      unique case (r_state)
        EMPTY: if (w_accept) begin
          w_next    = ONE;
          w_loadOut = 1'b1;
        end
        ONE: if (w_accept && w_consume) begin
          w_loadOut = 1'b1;
        end else if (w_consume) begin
          w_next = EMPTY;
        end else if (w_accept) begin
          w_next     = FULL;
          w_loadSkid = 1'b1;
        end
        FULL: if (w_consume) begin
          w_next     = ONE;
          w_loadOut  = 1'b1;
          w_fromSkid = 1'b1;
        end
        default: w_next = EMPTY;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_outAlu <= '0;
      r_outOp1 <= '0;
      r_outOp2 <= '0;
      r_outRd  <= '0;
      r_skAlu  <= '0;
      r_skOp1  <= '0;
      r_skOp2  <= '0;
      r_skRd   <= '0;
    end else begin
      if (w_loadOut && w_fromSkid) begin
        r_outAlu <= r_skAlu;
        r_outOp1 <= r_skOp1;
        r_outOp2 <= r_skOp2;
        r_outRd  <= r_skRd;
      end else if (w_loadOut) begin
        r_outAlu <= bus.inAluCode;
        r_outOp1 <= w_op1;
        r_outOp2 <= w_op2;
        r_outRd  <= bus.inRd;
      end
      if (w_loadSkid) begin
        r_skAlu <= bus.inAluCode;
        r_skOp1 <= w_op1;
        r_skOp2 <= w_op2;
        r_skRd  <= bus.inRd;
      end
    end
  end
endmodule

// File: tb/tb_int_operand_stage.sv
// Directed vector bench for int_operand_stage.
// Table of resolve cases plus handshake/flush/reset sequences.
module tb_int_operand_stage;
  localparam logic [3:0] ALU_ADD  = 4'd0;
  localparam logic [3:0] ALU_SUB  = 4'd1;
  localparam logic [3:0] ALU_JUMP = 4'd12;

  typedef struct {
    logic [3:0]  alu;
    logic [4:0]  rs1, rs2, rd;
    logic [31:0] rf1, rf2, pc, imm;
    logic [1:0]  s1, s2;
    logic        exV;
    logic [4:0]  exRd;
    logic [31:0] exD;
    logic        memV;
    logic [4:0]  memRd;
    logic [31:0] memD;
    logic        wbV;
    logic [4:0]  wbRd;
    logic [31:0] wbD;
    logic [31:0] e1, e2;
  } vec_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic flush = 1'b0;
  int n_vec = 0;
  int n_err = 0;
  vec_t v [8];

  int_operand_stage_if bus ();

  int_operand_stage dut (
    .clk  (clk),
    .rst  (rst),
    .flush(flush),
    .bus  (bus)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
    end
  endtask

  function automatic vec_t simple(input logic [3:0] a,
                                  input logic [4:0] rd,
                                  input logic [31:0] d1);
    vec_t t;
    t = '{a, 5'd1, 5'd2, rd, d1, 32'h7, 32'h0, 32'h0,
          2'd0, 2'd0, 1'b0, 5'd0, 32'h0, 1'b0, 5'd0,
          32'h0, 1'b0, 5'd0, 32'h0, d1, 32'h7};
    return t;
  endfunction

  task automatic drv(input vec_t t, input logic vld);
    bus.inValid     = vld;
    bus.inAluCode   = t.alu;
    bus.inRs1       = t.rs1;
    bus.inRs2       = t.rs2;
    bus.inRd        = t.rd;
    bus.inRf1       = t.rf1;
    bus.inRf2       = t.rf2;
    bus.inPc        = t.pc;
    bus.inImm       = t.imm;
    bus.inOp1Sel    = t.s1;
    bus.inOp2Sel    = t.s2;
    bus.exFwdValid  = t.exV;
    bus.exFwdRd     = t.exRd;
    bus.exFwdData   = t.exD;
    bus.memFwdValid = t.memV;
    bus.memFwdRd    = t.memRd;
    bus.memFwdData  = t.memD;
`ifdef INT_OPERAND_WB_BYPASS_EN
    bus.wbFwdValid  = t.wbV;
    bus.wbFwdRd     = t.wbRd;
    bus.wbFwdData   = t.wbD;
`endif
  endtask

  task automatic expect_op(input string nm, input vec_t t);
    chk({nm, ".valid"}, {31'd0, bus.outValid}, 32'd1);
    chk({nm, ".op1"}, bus.outOp1, t.e1);
    chk({nm, ".op2"}, bus.outOp2, t.e2);
    chk({nm, ".rd"}, {27'd0, bus.outRd}, {27'd0, t.rd});
    chk({nm, ".alu"}, {28'd0, bus.outAluCode}, {28'd0, t.alu});
  endtask

  task automatic fill_full(input vec_t a, input vec_t b);
    bus.outReady = 1'b0;
    @(negedge clk); drv(a, 1'b1);
    @(negedge clk); drv(b, 1'b1);
    @(negedge clk); drv(b, 1'b0);
  endtask

  initial begin
    vec_t a, b, c;
    v[0] = simple(ALU_ADD, 5'd3, 32'h5);
    v[1] = '{ALU_ADD, 5'd3, 5'd0, 5'd4, 32'h33, 32'h0,
             32'h0, 32'h44, 2'd0, 2'd1,
             1'b1, 5'd3, 32'h11, 1'b1, 5'd3, 32'h22,
             1'b0, 5'd0, 32'h0, 32'h11, 32'h44};
    v[2] = '{ALU_SUB, 5'd3, 5'd0, 5'd4, 32'h33, 32'h0,
             32'h0, 32'h44, 2'd0, 2'd1,
             1'b0, 5'd3, 32'h11, 1'b1, 5'd3, 32'h22,
             1'b0, 5'd0, 32'h0, 32'h22, 32'h44};
    v[3] = '{ALU_ADD, 5'd0, 5'd0, 5'd5, 32'h55, 32'h77,
             32'h0, 32'h0, 2'd0, 2'd0,
             1'b1, 5'd0, 32'hFF, 1'b1, 5'd0, 32'hEE,
             1'b1, 5'd0, 32'hDD, 32'h0, 32'h0};
    v[4] = '{ALU_JUMP, 5'd0, 5'd0, 5'd1, 32'h0, 32'h0,
             32'h100, 32'h8, 2'd1, 2'd2,
             1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0,
             1'b0, 5'd0, 32'h0, 32'h100, 32'h100};
    v[5] = '{ALU_SUB, 5'd9, 5'd10, 5'd2, 32'h99, 32'hAA,
             32'h200, 32'h300, 2'd2, 2'd3,
             1'b1, 5'd9, 32'h1, 1'b1, 5'd10, 32'h2,
             1'b0, 5'd0, 32'h0, 32'h0, 32'h0};
    v[6] = '{ALU_ADD, 5'd7, 5'd6, 5'd8, 32'h70, 32'h60,
             32'h0, 32'h0, 2'd0, 2'd0,
             1'b1, 5'd7, 32'hCAFE, 1'b1, 5'd6, 32'hAB,
             1'b0, 5'd0, 32'h0, 32'hCAFE, 32'hAB};
    v[7] = '{ALU_ADD, 5'd4, 5'd4, 5'd9, 32'h1, 32'h1,
             32'h0, 32'h0, 2'd0, 2'd0,
             1'b0, 5'd0, 32'h0, 1'b1, 5'd5, 32'h3,
             1'b1, 5'd4, 32'h9, 32'h1, 32'h1};
`ifdef INT_OPERAND_WB_BYPASS_EN
    v[7].e1 = 32'h9;
    v[7].e2 = 32'h9;
`endif

    a = simple(ALU_ADD, 5'd10, 32'hA);
    drv(a, 1'b0);
    bus.outReady = 1'b1;
    #1;
    chk("rst.valid", {31'd0, bus.outValid}, 32'd0);
    chk("rst.ready", {31'd0, bus.inReady}, 32'd1);
    chk("rst.op1", bus.outOp1, 32'd0);
    @(negedge clk); rst = 1'b0;

    for (int i = 0; i < 8; i++) begin
      @(negedge clk); drv(v[i], 1'b1);
      @(negedge clk); drv(v[i], 1'b0);
      expect_op($sformatf("vec%0d", i), v[i]);
    end

    a = simple(ALU_ADD, 5'd3, 32'h5);
    b = simple(ALU_ADD, 5'd4, 32'h6);
    @(negedge clk); drv(a, 1'b1);
    @(negedge clk); drv(b, 1'b1);
    expect_op("b2b.a", a);
    chk("b2b.ready", {31'd0, bus.inReady}, 32'd1);
    @(negedge clk); drv(b, 1'b0);
    expect_op("b2b.b", b);
    @(negedge clk);
    chk("b2b.drain", {31'd0, bus.outValid}, 32'd0);

    a = simple(ALU_ADD, 5'd11, 32'hA);
    b = simple(ALU_SUB, 5'd12, 32'hB);
    c = simple(ALU_ADD, 5'd13, 32'hC);
    fill_full(a, b);
    chk("bp.ready", {31'd0, bus.inReady}, 32'd0);
    expect_op("bp.holdA", a);
    drv(c, 1'b1);
    @(negedge clk);
    expect_op("bp.stillA", a);
    drv(c, 1'b0);
    bus.outReady = 1'b1;
    @(negedge clk);
    expect_op("bp.B", b);
    chk("bp.ready2", {31'd0, bus.inReady}, 32'd1);
    @(negedge clk);
    chk("bp.empty", {31'd0, bus.outValid}, 32'd0);

    fill_full(a, b);
    flush = 1'b1;
    drv(c, 1'b1);
    @(negedge clk);
    flush = 1'b0;
    drv(c, 1'b0);
    chk("fl.valid", {31'd0, bus.outValid}, 32'd0);
    chk("fl.ready", {31'd0, bus.inReady}, 32'd1);
    bus.outReady = 1'b1;
    @(negedge clk);
    chk("fl.nocap", {31'd0, bus.outValid}, 32'd0);

    fill_full(a, b);
    rst = 1'b1;
    #1;
    chk("mrst.valid", {31'd0, bus.outValid}, 32'd0);
    chk("mrst.ready", {31'd0, bus.inReady}, 32'd1);
    chk("mrst.op1", bus.outOp1, 32'd0);
    chk("mrst.op2", bus.outOp2, 32'd0);
    chk("mrst.rd", {27'd0, bus.outRd}, 32'd0);
    chk("mrst.alu", {28'd0, bus.outAluCode}, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk("mrst.idle", {31'd0, bus.outValid}, 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==",
             n_vec, n_err);
    $finish;
  end
endmodule
